// File: rtl/led_fade_if.sv
// LED fade driver signal bundle: pattern/enable in, LED drive and debug status out.
interface led_fade_if #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned PWM_BITS = 4
);
    logic [N_CH-1:0]          pattern;
    logic                     enable;
    logic [N_CH-1:0]          led;
    logic [N_CH*PWM_BITS-1:0] level_flat;
    logic                     settled;

    modport master (
        output pattern,
        output enable,
        input  led,
        input  level_flat,
        input  settled
    );

    modport slave (
        input  pattern,
        input  enable,
        output led,
        output level_flat,
        output settled
    );
endinterface

// File: rtl/led_fade_driver.sv
// LED fade driver: each channel ramps its brightness one step per fade tick toward the
// target on/off state and is rendered with a free-running PWM counter.
module led_fade_driver #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned STEP_DIV = 3125000
) (
    input logic       clk,
    input logic       reset,
    led_fade_if.slave bus
);
    localparam int unsigned         CntW    = $clog2(STEP_DIV);
    localparam logic [PWM_BITS-1:0] MaxLvl  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZeroLvl = {PWM_BITS{1'b0}};
    localparam logic [CntW-1:0]     LastCnt = CntW'(STEP_DIV - 1);

    logic [N_CH-1:0]     pat_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] level_q [N_CH];
    logic [PWM_BITS-1:0] level_d [N_CH];
    logic [N_CH-1:0]     led_q, led_d;
    logic                settled_c;

    // Fade step timing: counter advances only while enabled, tick on its last value.
    always_comb begin
        step_tick = (cnt_q == LastCnt);
        cnt_d     = cnt_q;
        if (bus.enable) begin
            cnt_d = step_tick ? '0 : cnt_q + CntW'(1);
        end
    end

    // Saturating per-channel level ramp; the tick sees pat_q before this edge's update.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            level_d[i] = level_q[i];
            if (bus.enable && step_tick) begin
                if (pat_q[i] && (level_q[i] != MaxLvl)) begin
                    level_d[i] = level_q[i] + PWM_BITS'(1);
                end else if (!pat_q[i] && (level_q[i] != ZeroLvl)) begin
                    level_d[i] = level_q[i] - PWM_BITS'(1);
                end
            end
        end
    end

    // PWM compare: full level is forced solid on, otherwise level k gives k of 16 cycles.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            led_d[i] = bus.enable & ((level_q[i] == MaxLvl) | (level_q[i] > pwm_q));
        end
    end

    // Settled when every channel sits at the rail its target bit selects.
    always_comb begin
        settled_c = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (level_q[i] != (pat_q[i] ? MaxLvl : ZeroLvl)) begin
                settled_c = 1'b0;
            end
        end
    end

    // Flatten levels for the debug port.
    always_comb begin
        bus.level_flat = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.level_flat[i*PWM_BITS +: PWM_BITS] = level_q[i];
        end
    end

    assign bus.led     = led_q;
    assign bus.settled = settled_c;

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            cnt_q <= '0;
            pwm_q <= '0;
            led_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pat_q <= bus.pattern;
            cnt_q <= cnt_d;
            pwm_q <= pwm_q + PWM_BITS'(1);
            led_q <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end
endmodule
